// File: rtl/raiz_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module   : raiz_bin2bcd
//  Purpose  : Sequential binary-to-BCD converter (shift-add-3 / double dabble)
//             for the square-root root value. It runs one iteration per input
//             bit, and each iteration takes two clocks (add-3, then shift).
//             A Start/Done handshake controls each conversion.
//  Options  : RAIZ_BLANK_EN - when defined, a registered leading-zero mask
//             is produced on Blank. Otherwise Blank is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module raiz_bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Bin,
    output logic [4*DIGITS-1:0]   Bcd,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Overflow,
    output logic [DIGITS-1:0]     Blank
);

    // Iteration counter width: it must hold WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [2:0] {
        S_Idle  = 3'd0,
        S_Load  = 3'd1,
        S_Add3  = 3'd2,
        S_Shift = 3'd3,
        S_Done  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_q,    sh_d;
    logic [BW-1:0]     w_q,     w_d;
    logic              ovf_q,   ovf_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [BW-1:0]     bcd_q,   bcd_d;
    logic              ovfo_q,  ovfo_d;
    logic              done_q,  done_d;

    logic [BW-1:0]     w_add3;

    // Every digit >= 5 gets +3 in parallel, so that the following left
    // shift carries correctly into the next decimal digit.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        assign w_add3[4*k +: 4] = (w_q[4*k +: 4] >= 4'd5) ? (w_q[4*k +: 4] + 4'd3)
                                                            : w_q[4*k +: 4];
    end

    // State and datapath registers; reset wins over any conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_Idle;
            sh_q    <= '0;
            w_q     <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovfo_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            w_q     <= w_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovfo_q  <= ovfo_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update logic. Every register holds its value
    // by default.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        w_d     = w_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovfo_d  = ovfo_q;
        done_d  = 1'b0;

        case (state_q)
            S_Idle: begin
                if (Start) begin
                    state_d = S_Load;
                end
            end

            S_Load: begin
                sh_d    = Bin;
                w_d     = '0;
                ovf_d   = 1'b0;
                cnt_d   = CW'(WIDTH);
                state_d = S_Add3;
            end

            S_Add3: begin
                w_d     = w_add3;
                state_d = S_Shift;
            end

            S_Shift: begin
                // {w, sh} shift left as one register. A 1 leaving the top
                // digit means the value does not fit in DIGITS digits.
                w_d   = {w_q[BW-2:0], sh_q[WIDTH-1]};
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                ovf_d = ovf_q | w_q[BW-1];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_Done;
                end else begin
                    state_d = S_Add3;
                end
            end

            S_Done: begin
                // Publish the result. Done is registered alongside Bcd so
                // that it rises in the same cycle that the new Bcd appears.
                bcd_d   = w_q;
                ovfo_d  = ovf_q;
                done_d  = 1'b1;
                state_d = S_Idle;
            end

            default: begin
                state_d = S_Idle;
            end
        endcase
    end

    assign Bcd      = bcd_q;
    assign Overflow = ovfo_q;
    assign Done     = done_q;
    assign Busy     = (state_q != S_Idle);

`ifdef RAIZ_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] w_blank;

    // The units digit is never blanked, so a zero value still shows "0".
    assign w_blank[0] = 1'b0;
    for (genvar k = 1; k < DIGITS; k++) begin : g_blank
        assign w_blank[k] = ~|w_q[BW-1:4*k];
    end

    // The blank mask is latched in the same cycle as Bcd, so the two always
    // describe the same value.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= '0;
        end else if (state_q == S_Done) begin
            blank_q <= w_blank;
        end
    end

    assign Blank = blank_q;
`else
    assign Blank = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_raiz_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_raiz_bin2bcd
//  Purpose  : Scoreboard testbench for raiz_bin2bcd. It drives a 5-digit
//             instance and a 4-digit instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_raiz_bin2bcd;

    localparam int LAT = 34;

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        start5 = 1'b0;
    logic [15:0] bin5 = '0;
    logic [19:0] bcd5;
    logic        busy5, done5, ovf5;
    logic [4:0]  blank5;

    logic        start4 = 1'b0;
    logic [15:0] bin4 = '0;
    logic [15:0] bcd4;
    logic        busy4, done4, ovf4;
    logic [3:0]  blank4;

    exp_t q5[$];
    exp_t q4[$];

    raiz_bin2bcd #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clk(clk), .reset(reset), .Start(start5), .Bin(bin5), .Bcd(bcd5),
        .Busy(busy5), .Done(done5), .Overflow(ovf5), .Blank(blank5)
    );

    raiz_bin2bcd #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .Start(start4), .Bin(bin4), .Bcd(bcd4),
        .Busy(busy4), .Done(done4), .Overflow(ovf4), .Blank(blank4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The expected Blank value depends on whether blanking is built in.
    function automatic logic [4:0] bl(input logic [4:0] m);
`ifdef RAIZ_BLANK_EN
        return m;
`else
        return 5'b0 & m;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the 5-digit instance.
    always @(negedge clk) begin : mon5
        exp_t e;
        if (!reset && done5) begin
            if (q5.size() == 0) begin
                chk("done5_unexpected", 32'(done5), 32'd0);
            end else begin
                e = q5.pop_front();
                chk("bcd5", 32'(bcd5), 32'(e.bcd));
                chk("ovf5", 32'(ovf5), 32'(e.ovf));
                chk("blank5", 32'(blank5), 32'(e.blank));
                chk("lat5", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Scoreboard monitor for the 4-digit instance.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (!reset && done4) begin
            if (q4.size() == 0) begin
                chk("done4_unexpected", 32'(done4), 32'd0);
            end else begin
                e = q4.pop_front();
                chk("bcd4", 32'(bcd4), 32'(e.bcd[15:0]));
                chk("ovf4", 32'(ovf4), 32'(e.ovf));
                chk("blank4", 32'(blank4), 32'(e.blank[3:0]));
                chk("lat4", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic go5(input logic [15:0] b, input bit push,
                       input logic [19:0] eb, input logic eo, input logic [4:0] ebl);
        exp_t e;
        @(negedge clk);
        start5 = 1'b1;
        bin5   = b;
        @(posedge clk);
        #1;
        start5 = 1'b0;
        if (push) begin
            e.bcd = eb; e.ovf = eo; e.blank = ebl; e.cyc = cyc + LAT;
            q5.push_back(e);
        end
        @(negedge clk);
        chk("busy5_after_start", 32'(busy5), 32'd1);
    endtask

    task automatic go4(input logic [15:0] b, input logic [19:0] eb, input logic eo,
                       input logic [4:0] ebl);
        exp_t e;
        @(negedge clk);
        start4 = 1'b1;
        bin4   = b;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        e.bcd = eb; e.ovf = eo; e.blank = ebl; e.cyc = cyc + LAT;
        q4.push_back(e);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q5.size() != 0 || q4.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (q5.size() != 0 || q4.size() != 0)
            chk("drain_timeout", 32'(q5.size() + q4.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        exp_t e;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_bcd", 32'(bcd5), 32'd0);
        chk("rst_busy", 32'(busy5), 32'd0);
        chk("rst_done", 32'(done5), 32'd0);
        chk("rst_ovf", 32'(ovf5), 32'd0);
        chk("rst_blank", 32'(blank5), 32'd0);

        go5(16'd12, 1'b1, 20'h00012, 1'b0, bl(5'b11100));
        drain(100);
        go5(16'd65535, 1'b1, 20'h65535, 1'b0, bl(5'b00000));
        drain(100);
        go5(16'd0, 1'b1, 20'h00000, 1'b0, bl(5'b11110));
        drain(100);
        go5(16'd305, 1'b1, 20'h00305, 1'b0, bl(5'b11000));
        drain(100);

        // A second Start mid-conversion is ignored, and a Bin change has no effect.
        go5(16'd4321, 1'b1, 20'h04321, 1'b0, bl(5'b10000));
        repeat (8) @(negedge clk);
        chk("bcd5_hold_busy", 32'(bcd5), 32'h00305);
        start5 = 1'b1;
        bin5   = 16'd999;
        @(negedge clk);
        start5 = 1'b0;
        bin5   = 16'h1234;
        drain(100);
        repeat (10) @(negedge clk);

        // Reset during a conversion: the conversion is aborted without a Done pulse.
        go5(16'd777, 1'b0, 20'h0, 1'b0, 5'b0);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy5), 32'd0);
        chk("midrst_bcd", 32'(bcd5), 32'd0);
        chk("midrst_done", 32'(done5), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        go5(16'd9876, 1'b1, 20'h09876, 1'b0, bl(5'b10000));
        drain(100);

        // Start held high: two conversions run back to back, with one idle
        // cycle between them.
        @(negedge clk);
        start5 = 1'b1;
        bin5   = 16'd100;
        @(posedge clk);
        #1;
        e.bcd = 20'h00100; e.ovf = 1'b0; e.blank = bl(5'b11000);
        e.cyc = cyc + LAT;
        q5.push_back(e);
        e.cyc = cyc + 2 * LAT + 1;
        q5.push_back(e);
        repeat (LAT + 1) @(posedge clk);
        #1;
        start5 = 1'b0;
        drain(100);

        // Four-digit instance: an overflowing value, then the largest value that fits.
        go4(16'd12345, 20'h02345, 1'b1, bl(5'b00000));
        drain(100);
        go4(16'd9999, 20'h09999, 1'b0, bl(5'b00000));
        drain(100);
        chk("ovf4_held", 32'(ovf4), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
